// File: rtl/countdown_pkg.sv
// ----------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the six-digit BCD countdown timer (MM:SS.hh):
//   - state_e      : controller states
//   - digit maxima : units digits wrap to 9, tens-of-seconds/minutes to 5
//   - BTN_EDGE     : button-history pattern that marks a fresh press
//   - SEG_*        : active-low seven-segment glyphs {g,f,e,d,c,b,a}
//   - seg7()       : BCD digit to glyph decode
//   - clamp_digit(): saturates an out-of-range preset digit
//   - digit_max()  : wrap value for a given digit position (0 = hundredths)
// ----------------------------------------------------------------------------
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } state_e;

    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    // Two older samples low, two newest high: exactly one pulse per press.
    localparam logic [3:0] BTN_EDGE = 4'b0011;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = SEG_0;
            4'd1:    seg7 = SEG_1;
            4'd2:    seg7 = SEG_2;
            4'd3:    seg7 = SEG_3;
            4'd4:    seg7 = SEG_4;
            4'd5:    seg7 = SEG_5;
            4'd6:    seg7 = SEG_6;
            4'd7:    seg7 = SEG_7;
            4'd8:    seg7 = SEG_8;
            4'd9:    seg7 = SEG_9;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        clamp_digit = (d > max) ? max : d;
    endfunction

    // Digit 3 (tens of seconds) and digit 5 (tens of minutes) are base-6.
    function automatic logic [3:0] digit_max(input int idx);
        digit_max = (idx == 3 || idx == 5) ? TENS_MAX : UNITS_MAX;
    endfunction

endpackage

// File: rtl/countdown_tick_gen.sv
// ----------------------------------------------------------------------------
// countdown_tick_gen
// Free-running divider producing a one-cycle tick every CLKS_PER_TICK clocks.
// Paces the hundredths decrement and, in the blink build, the blink timer.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   clr   in  restart the divider so the next tick is CLKS_PER_TICK cycles away
//   tick  out high for one cycle at terminal count
// ----------------------------------------------------------------------------
module countdown_tick_gen #(
    parameter int unsigned CLKS_PER_TICK = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == W'(CLKS_PER_TICK - 1));

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values of the others, like real hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// ----------------------------------------------------------------------------
// countdown_timer
// Six-digit BCD countdown timer MM:SS.hh (max 59:59.99) with start/pause and
// preset-load buttons, alarm at zero, six active-low seven-segment outputs.
//   clk, rst_n             clock, asynchronous active-low reset
//   start, load            raw buttons, active high
//   preset_min, preset_sec BCD presets {tens, units}, clamped to 59 on load
//   HEX0..HEX5             segments {g,f,e,d,c,b,a}; HEX0 = hundredths units
//   alarm                  high while EXPIRED
//   running                high while RUN
// Build option: define COUNTDOWN_BLINK_EN to blink the display while expired
// (toggles every BLINK_TICKS ticks); otherwise the display is steady.
// ----------------------------------------------------------------------------
module countdown_timer #(
    parameter int unsigned CLKS_PER_TICK = 500000
`ifdef COUNTDOWN_BLINK_EN
    , parameter int unsigned BLINK_TICKS = 25
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       load,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic       alarm,
    output logic       running
);

    import countdown_pkg::*;

    state_e          state_q;
    logic [5:0][3:0] dig_q;
    logic [3:0]      start_sr_q;
    logic [3:0]      load_sr_q;

    logic            start_evt;
    logic            load_evt;
    logic            tick;
    logic            enter_run;
    logic            count_zero;
    logic            count_one;
    logic            show_blank;
    logic [5:0][3:0] dig_dec_d;
    logic [5:0][3:0] dig_preset_d;

    assign start_evt  = (start_sr_q == BTN_EDGE);
    assign load_evt   = (load_sr_q == BTN_EDGE);
    assign count_zero = (dig_q == 24'h000000);
    assign count_one  = (dig_q == 24'h000001);

    // Load outranks start, so a start only enters RUN when no load is acting.
    assign enter_run = start_evt && !load_evt &&
                       ((state_q == IDLE && !count_zero) || state_q == PAUSE);

    assign dig_preset_d = {clamp_digit(preset_min[7:4], TENS_MAX),
                           clamp_digit(preset_min[3:0], UNITS_MAX),
                           clamp_digit(preset_sec[7:4], TENS_MAX),
                           clamp_digit(preset_sec[3:0], UNITS_MAX),
                           4'd0, 4'd0};

    // Ripple-borrow decrement from the hundredths digit upwards.
    always_comb begin : dec_chain
        logic borrow;
        // NOTE: every combinational output is given a default before any
        // conditional assignment, so no path can leave it unassigned (latch).
        dig_dec_d = dig_q;
        borrow    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (dig_q[i] == 4'd0) begin
                    dig_dec_d[i] = digit_max(i);
                end else begin
                    dig_dec_d[i] = dig_q[i] - 4'd1;
                    borrow       = 1'b0;
                end
            end
        end
    end

    countdown_tick_gen #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (enter_run),
        .tick (tick)
    );

    // Reset to all-ones so a button held through reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sr_q <= 4'hF;
            load_sr_q  <= 4'hF;
        end else begin
            start_sr_q <= {start_sr_q[2:0], start};
            load_sr_q  <= {load_sr_q[2:0], load};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dig_q   <= '0;
        end else if (load_evt && state_q != RUN) begin
            state_q <= IDLE;
            dig_q   <= dig_preset_d;
        end else if (start_evt) begin
            case (state_q)
                IDLE:    if (!count_zero) state_q <= RUN;
                RUN:     state_q <= PAUSE;
                PAUSE:   state_q <= RUN;
                EXPIRED: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end else if (state_q == RUN && tick) begin
            // Decrementing 00:00.01 yields exactly zero, so only the state
            // needs special handling on the final tick.
            dig_q <= dig_dec_d;
            if (count_one) begin
                state_q <= EXPIRED;
            end
        end
    end

`ifdef COUNTDOWN_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [BW-1:0] blink_cnt_q;
    logic          blank_q;

    // Digits visible on entry; the phase restarts each time EXPIRED is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else if (state_q != EXPIRED) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_q <= '0;
                blank_q     <= ~blank_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end
    end

    assign show_blank = blank_q;
`else
    assign show_blank = 1'b0;
`endif

    assign HEX0 = show_blank ? SEG_BLANK : seg7(dig_q[0]);
    assign HEX1 = show_blank ? SEG_BLANK : seg7(dig_q[1]);
    assign HEX2 = show_blank ? SEG_BLANK : seg7(dig_q[2]);
    assign HEX3 = show_blank ? SEG_BLANK : seg7(dig_q[3]);
    assign HEX4 = show_blank ? SEG_BLANK : seg7(dig_q[4]);
    assign HEX5 = show_blank ? SEG_BLANK : seg7(dig_q[5]);

    assign alarm   = (state_q == EXPIRED);
    assign running = (state_q == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_countdown_timer
// Directed bench for countdown_timer with CLKS_PER_TICK = 4. A behavioural
// model tracks the remaining time as an integer number of hundredths and is
// compared with the DUT every falling clock edge; literal expectations at key
// points pin the model itself.
// ----------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int N = 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_EXP   = 3;

    localparam logic [6:0] GLYPH [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       load;
    logic [7:0] preset_min;
    logic [7:0] preset_sec;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic       alarm;
    logic       running;
    logic [41:0] hex_all;

    int n_vec = 0;
    int n_err = 0;

    assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    always #5 clk = ~clk;

    countdown_timer #(
        .CLKS_PER_TICK(N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .load      (load),
        .preset_min(preset_min),
        .preset_sec(preset_sec),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5),
        .alarm     (alarm),
        .running   (running)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int         st;
        int         cnt;   // remaining time in hundredths of a second
        int         ph;    // clocks since the last tick / run entry
        logic [3:0] hs;    // last four start samples, newest in bit 0
        logic [3:0] hl;    // last four load samples, newest in bit 0
    } model_t;

    model_t m;

    function automatic model_t reset_model();
        model_t r;
        r.st  = S_IDLE;
        r.cnt = 0;
        r.ph  = 0;
        r.hs  = 4'hF;
        r.hl  = 4'hF;
        return r;
    endfunction

    function automatic int clamp(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int preset_hundredths(logic [7:0] pm, logic [7:0] ps);
        int mins = clamp(int'(pm[7:4]), 5) * 10 + clamp(int'(pm[3:0]), 9);
        int secs = clamp(int'(ps[7:4]), 5) * 10 + clamp(int'(ps[3:0]), 9);
        return mins * 6000 + secs * 100;
    endfunction

    function automatic logic [41:0] disp(int cnt);
        int hh  = cnt % 100;
        int sec = (cnt / 100) % 60;
        int mn  = cnt / 6000;
        return {GLYPH[mn / 10], GLYPH[mn % 10], GLYPH[sec / 10], GLYPH[sec % 10],
                GLYPH[hh / 10], GLYPH[hh % 10]};
    endfunction

    function automatic model_t step(model_t c, logic s, logic l,
                                    logic [7:0] pm, logic [7:0] ps);
        model_t n     = c;
        bit     s_evt = (c.hs == 4'b0011);
        bit     l_evt = (c.hl == 4'b0011);
        bit     tk    = (c.ph == N - 1);
        n.hs = {c.hs[2:0], s};
        n.hl = {c.hl[2:0], l};
        n.ph = tk ? 0 : c.ph + 1;
        if (l_evt && c.st != S_RUN) begin
            n.cnt = preset_hundredths(pm, ps);
            n.st  = S_IDLE;
        end else if (s_evt) begin
            case (c.st)
                S_IDLE:  if (c.cnt != 0) begin n.st = S_RUN; n.ph = 0; end
                S_RUN:   n.st = S_PAUSE;
                S_PAUSE: begin n.st = S_RUN; n.ph = 0; end
                default: n.st = S_IDLE;
            endcase
        end else if (c.st == S_RUN && tk) begin
            n.cnt = c.cnt - 1;
            if (n.cnt == 0) n.st = S_EXP;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= reset_model();
        else        m <= step(m, start, load, preset_min, preset_sec);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_hex", hex_all, disp(m.cnt));
        check("model_alarm", {41'd0, alarm}, {41'd0, m.st == S_EXP});
        check("model_running", {41'd0, running}, {41'd0, m.st == S_RUN});
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the chosen buttons for three samples; the event acts on the third
    // rising edge and the task returns on the falling edge right after it.
    task automatic press(input logic do_start, input logic do_load);
        if (do_start) start = 1'b1;
        if (do_load)  load  = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        load  = 1'b0;
    endtask

    initial begin
        start      = 1'b0;
        load       = 1'b0;
        preset_min = 8'h00;
        preset_sec = 8'h00;
        rst_n      = 1'b1;
        #2 rst_n   = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(4);

        // Reset state
        check("reset_hex", hex_all, {6{GLYPH[0]}});
        check("reset_alarm", {41'd0, alarm}, 42'd0);
        check("reset_running", {41'd0, running}, 42'd0);

        // Start with zero count is ignored; preset clamping
        press(1'b1, 1'b0);
        idle(4);
        check("zero_start_idle", {41'd0, running}, 42'd0);
        preset_sec = 8'h7C;
        press(1'b0, 1'b1);
        idle(2);
        check("clamp_d3", {35'd0, HEX3}, {35'd0, GLYPH[5]});
        check("clamp_d2", {35'd0, HEX2}, {35'd0, GLYPH[9]});

        // 00:01.00 runs to expiry after 100 ticks
        preset_sec = 8'h01;
        press(1'b0, 1'b1);
        idle(2);
        check("load_1s", hex_all, {GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[1], GLYPH[0], GLYPH[0]});
        press(1'b1, 1'b0);
        idle(399);
        check("last_hundredth", hex_all, {GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[1]});
        check("not_yet_alarm", {41'd0, alarm}, 42'd0);
        idle(1);
        check("expired_alarm", {41'd0, alarm}, 42'd1);
        check("expired_running", {41'd0, running}, 42'd0);
        check("expired_hex", hex_all, {6{GLYPH[0]}});
        idle(20);
        check("expired_held", hex_all, {6{GLYPH[0]}});
        press(1'b1, 1'b0);
        idle(2);
        check("expired_to_idle", {41'd0, alarm}, 42'd0);

        // 01:00.00 borrows through every digit on the first tick
        preset_min = 8'h01;
        preset_sec = 8'h00;
        press(1'b0, 1'b1);
        idle(2);
        press(1'b1, 1'b0);
        idle(4);
        check("borrow_all", hex_all, {GLYPH[0], GLYPH[0], GLYPH[5], GLYPH[9], GLYPH[9], GLYPH[9]});
        preset_min = 8'h03;
        press(1'b0, 1'b1);
        idle(2);
        check("load_in_run_ignored", {28'd0, HEX5, HEX4}, {28'd0, GLYPH[0], GLYPH[0]});
        check("load_in_run_running", {41'd0, running}, 42'd1);
        press(1'b1, 1'b0);
        idle(3);
        check("paused", {41'd0, running}, 42'd0);

        // Pause after 3 ticks, freeze, resume with exact first-tick latency
        preset_min = 8'h00;
        preset_sec = 8'h01;
        press(1'b0, 1'b1);
        idle(2);
        press(1'b1, 1'b0);
        idle(11);
        press(1'b1, 1'b0);
        check("pause_after_3", {41'd0, running}, 42'd0);
        idle(80);
        check("frozen_97", hex_all, {GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[9], GLYPH[7]});
        press(1'b1, 1'b0);
        idle(3);
        check("resume_pre_tick", hex_all, {GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[9], GLYPH[7]});
        idle(1);
        check("resume_first_tick", hex_all, {GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[9], GLYPH[6]});

        // Start and load together in PAUSE: load wins
        idle(2);
        press(1'b1, 1'b0);
        idle(3);
        preset_min = 8'h02;
        preset_sec = 8'h30;
        press(1'b1, 1'b1);
        idle(2);
        check("both_load_hex", hex_all, {GLYPH[0], GLYPH[2], GLYPH[3], GLYPH[0], GLYPH[0], GLYPH[0]});
        idle(10);
        check("both_start_dropped", {41'd0, running}, 42'd0);

        // Asynchronous reset mid-RUN with both buttons held
        press(1'b1, 1'b0);
        idle(10);
        check("run_before_reset", {41'd0, running}, 42'd1);
        #2;
        start = 1'b1;
        load  = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_hex", hex_all, {6{GLYPH[0]}});
        check("async_rst_running", {41'd0, running}, 42'd0);
        idle(2);
        rst_n = 1'b1;
        idle(10);
        check("held_no_load", hex_all, {6{GLYPH[0]}});
        check("held_no_start", {41'd0, running}, 42'd0);
        start = 1'b0;
        load  = 1'b0;
        idle(3);
        press(1'b0, 1'b1);
        idle(2);
        check("repress_load", hex_all, {GLYPH[0], GLYPH[2], GLYPH[3], GLYPH[0], GLYPH[0], GLYPH[0]});
        press(1'b1, 1'b0);
        idle(8);
        check("repress_start", {41'd0, running}, 42'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
